// File: rtl/universal_adder_pkg.sv
// Shared constants for the universal_adder add/subtract slice.
package universal_adder_pkg;

    localparam logic        MODE_ADD      = 1'b0;
    localparam logic        MODE_SUB      = 1'b1;
    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/universal_adder_full_adder_bit.sv
// One-bit full adder; the top level chains WIDTH of these into a ripple-carry adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/universal_adder.sv
// Registered unsigned add/subtract unit (one ripple-carry chain, 1-cycle latency).
// Define UNIVERSAL_ADDER_OVF_EN to add the registered signed-overflow output OVF.
module universal_adder
    import universal_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MODE,
`ifdef UNIVERSAL_ADDER_OVF_EN
    output logic             OVF,
`endif
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY_BORROW
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_borrow_d, carry_borrow_q;

    // Subtract is A + ~B + 1: invert B and feed MODE in as the carry-in.
    assign b_eff    = B ^ {WIDTH{MODE}};
    assign carry[0] = MODE;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_bit u_fa (
            .a    (A[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    always_comb begin
        result_d       = sum;
        // Chain carry-out is the inverse of the borrow when subtracting.
        carry_borrow_d = (MODE == MODE_SUB) ? ~carry[WIDTH] : carry[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q       <= '0;
            carry_borrow_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            carry_borrow_q <= carry_borrow_d;
        end
    end

    assign RESULT       = result_q;
    assign CARRY_BORROW = carry_borrow_q;

`ifdef UNIVERSAL_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_universal_adder.sv
// Self-checking bench for universal_adder (WIDTH=4): random stimulus vs. an arithmetic model,
// plus literal expectations. Honours UNIVERSAL_ADDER_OVF_EN when defined.
module tb_universal_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         mode;
    logic [W-1:0] result;
    logic         carry_borrow;
    logic         ovf;

    int n_total;
    int n_pass;
    bit chk_en;

    universal_adder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .A            (a_in),
        .B            (b_in),
        .MODE         (mode),
`ifdef UNIVERSAL_ADDER_OVF_EN
        .OVF          (ovf),
`endif
        .RESULT       (result),
        .CARRY_BORROW (carry_borrow)
    );

`ifndef UNIVERSAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model from plain integer arithmetic: {ovf, carry_borrow, result}.
    function automatic logic [W+1:0] model(input int a, input int b, input bit m);
        int full, sa, sb, sr;
        logic [W-1:0] r;
        logic cb, ov;
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        if (!m) begin
            full = a + b;
            cb   = (full >= (1 << W));
            sr   = sa + sb;
        end else begin
            full = a - b;
            cb   = (a < b);
            sr   = sa - sb;
        end
        r  = W'(full & ((1 << W) - 1));
        ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        return {ov, cb, r};
    endfunction

    // Per-cycle compare: expectation taken from inputs at the edge, checked 1 time unit later.
    always @(posedge clk) begin
        logic [W+1:0] e;
        bit           en;
        en = chk_en;
        if (rst) e = '0;
        else     e = model(int'(a_in), int'(b_in), mode);
        #1;
        if (en) begin
            check("model_result", int'(result), int'(e[W-1:0]));
            check("model_cb", int'(carry_borrow), int'(e[W]));
`ifdef UNIVERSAL_ADDER_OVF_EN
            check("model_ovf", int'(ovf), int'(e[W+1]));
`endif
        end
    end

    task automatic apply(input int a, input int b, input bit m);
        @(negedge clk);
        a_in = W'(a);
        b_in = W'(b);
        mode = m;
    endtask

    task automatic expect_lit(input string name, input int r, input int cb);
        @(posedge clk);
        #1;
        check({name, "_result"}, int'(result), r);
        check({name, "_cb"}, int'(carry_borrow), cb);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        chk_en  = 1'b0;
        rst     = 1'b1;
        a_in    = '0;
        b_in    = '0;
        mode    = 1'b0;
        #2;
        check("reset_result", int'(result), 0);
        check("reset_cb", int'(carry_borrow), 0);
        check("reset_ovf", int'(ovf), 0);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        apply(5, 3, 0);  expect_lit("add_5_3", 8, 0);
        apply(7, 9, 0);  expect_lit("add_7_9", 0, 1);
        apply(9, 2, 1);  expect_lit("sub_9_2", 7, 0);
        apply(4, 9, 1);  expect_lit("sub_4_9", 11, 1);
        apply(15, 15, 0); expect_lit("add_ones", 14, 1);
        apply(0, 0, 0);  expect_lit("add_zero", 0, 0);
        apply(13, 13, 1); expect_lit("sub_equal", 0, 0);
        apply(0, 1, 1);  expect_lit("sub_0_1", 15, 1);

`ifdef UNIVERSAL_ADDER_OVF_EN
        apply(7, 1, 0);  expect_lit("ovf_add", 8, 0);
        check("ovf_add_flag", int'(ovf), 1);
        apply(8, 1, 1);  expect_lit("ovf_sub", 7, 0);
        check("ovf_sub_flag", int'(ovf), 1);
        apply(3, 2, 0);  expect_lit("no_ovf", 5, 0);
        check("no_ovf_flag", int'(ovf), 0);
`endif

        // Back-to-back random operations, mode flipping freely.
        repeat (300) begin
            apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges, then recovery on the first edge after release.
        apply(5, 3, 0);
        @(posedge clk);
        #2;
        check("pre_reset_result", int'(result), 8);
        rst = 1'b1;
        #1;
        check("async_reset_result", int'(result), 0);
        check("async_reset_cb", int'(carry_borrow), 0);
        @(negedge clk);
        check("held_reset_result", int'(result), 0);
        rst  = 1'b0;
        a_in = W'(6);
        b_in = W'(6);
        mode = 1'b1;
        expect_lit("post_reset_sub", 0, 0);
        apply(2, 5, 1); expect_lit("post_reset_next", 13, 1);

        @(negedge clk);
        chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
